ddr3_port_arbiter: RTL and testbench
====================================

# ddr3_port_arbiter

Two-requester arbiter that shares the single DDR3 controller Avalon port between the write-back accumulator and a second DDR3 master (input/weight loader). Each requester sees a private Avalon-style port with `avl_wait_request_n` (active-high ready) semantics. The arbiter serialises single-beat reads and writes with round-robin fairness, holds a grant until its transaction completes, and guards reads with a response timeout.

## Interface
- `ADDR_W`, 26, DDR3 word address width
- `DATA_W`, 128, data beat width
- `RD_TIMEOUT`, 255, max cycles in RD_DATA before forced completion (1..65535)

- `iCLK` in 1: single clock, all logic on rising edge
- `iRST` in 1: reset, asynchronous, active-high
- `r0_read`, `r1_read` in 1: read request, held until acked
- `r0_write`, `r1_write` in 1: write request, held until acked
- `r0_address`, `r1_address` in ADDR_W: request address
- `r0_writedata`, `r1_writedata` in DATA_W: write data
- `r0_wait_request_n`, `r1_wait_request_n` out 1: one-cycle ack pulse, transaction complete
- `r0_readdata`, `r1_readdata` out DATA_W: read data, valid with readdatavalid
- `r0_readdatavalid`, `r1_readdatavalid` out 1: one-cycle read-data pulse
- `avl_address` out ADDR_W: controller address
- `avl_writedata` out DATA_W: controller write data
- `avl_read`, `avl_write` out 1: controller command
- `avl_burstbegin` out 1: high on first cycle of each command only
- `avl_wait_request_n` in 1: controller accepts command when high
- `avl_readdata` in DATA_W: controller read data
- `avl_readdatavalid` in 1: controller read data valid
- `grant` out 2: one-hot owner, 0 when idle
- `timeout_err` out 1: sticky, set on any read timeout

## Operation
- States: IDLE, WR, RD_CMD, RD_DATA, DONE.
- IDLE: if any request is pending, select the winner, latch its address/writedata/command into output registers, set `grant`, and enter WR (write) or RD_CMD (read). If neither requester is pending, stay.
- Tie: the requester not granted last wins; `last_grant` resets to 1 so r0 wins the first tie.
- read and write asserted together by one requester: treated as write.
- WR/RD_CMD: `avl_write`/`avl_read` held high until a cycle with `avl_wait_request_n`=1. Then the command drops next cycle.
  - WR goes to DONE.
  - RD_CMD goes to RD_DATA.
- RD_DATA: on `avl_readdatavalid`, register `avl_readdata` into the granted `rX_readdata` and go to DONE. The 16-bit counter increments each cycle in this state. On reaching RD_TIMEOUT: set `timeout_err`, load readdata with 0, go to DONE.
- DONE: exactly one cycle.
  - Granted `rX_wait_request_n`=1; for reads, also `rX_readdatavalid`=1.
  - `last_grant` updated; `grant` cleared on exit to IDLE.
- Requester must drop or change its request on the edge ending the DONE cycle.
- `avl_readdatavalid` outside RD_DATA is ignored.
- The non-granted requester's ack/valid stay 0. `rX_readdata` holds its last value.

## Timing
- All outputs registered. Reset values: every 1-bit output 0, `avl_address`/`avl_writedata`/`rX_readdata` 0, `grant` 0, `timeout_err` 0, state IDLE, `last_grant`=1, counter 0.
- Write, controller ready immediately:
  - request visible cycle 0 (IDLE)
  - `avl_write` and `avl_burstbegin` high cycle 1
  - ack cycle 2 (DONE)
  - IDLE cycle 3; the next command can issue at cycle 4.
- Read: command at cycle 1, RD_DATA from cycle 2. If `avl_readdatavalid` arrives in cycle k, data and ack appear in cycle k+1.
- Controller stall in WR/RD_CMD is unbounded; address, data and command are held stable.
- Reset mid-transaction:
  - in-flight command abandoned, all outputs to reset values within the same cycle (async)
  - a late `avl_readdatavalid` after reset is ignored.
- Timeout: with no readdatavalid, DONE occurs RD_TIMEOUT+1 cycles after entering RD_DATA.

## Structure
- Package `ddr3_arb_pkg`: state enum (IDLE, WR, RD_CMD, RD_DATA, DONE), default ADDR_W/DATA_W constants, requester index type.
- Sub-module `rr_arb2`: combinational two-way round-robin pick from (req[1:0], last_grant) to one-hot grant. The FSM, registers and timeout counter stay in the top.

## Test plan
- Single write: r0 writes addr 0x000010, data 0xA5..A5, controller ready.
  - Required: `avl_write` high in cycle 1 with that address/data and `avl_burstbegin` high.
  - Required: `r0_wait_request_n` pulses in cycle 2, `grant`=01 in cycles 1-2.
- Contention: r0 and r1 both write from reset.
  - Required: r0 served first, then r1, then r0 again if it re-requests.
  - Required: `grant` sequence 01, 10, 01; no requester is starved.
- Read with latency: r1 reads 0x0000FF; controller holds `avl_wait_request_n`=0 for 3 cycles, then returns 0x1234 four cycles after accept.
  - Required: `avl_read` held 4 cycles.
  - Required: `r1_readdatavalid` with 0x1234 exactly one cycle after `avl_readdatavalid`; `r0_readdatavalid` stays 0.
- Timeout: RD_TIMEOUT=8, r0 reads, no readdatavalid.
  - Required: r0 ack and readdatavalid with data 0 nine cycles after entering RD_DATA; `timeout_err`=1 and stays set.
- Reset mid-read: assert `iRST` during RD_DATA, deassert, then send a stray `avl_readdatavalid`.
  - Required: all outputs 0 immediately and no ack generated.
  - Required: a subsequent r1 request is served normally.

Source files
------------

// File: rtl/ddr3_arb_pkg.sv
// Shared types and defaults for the two-port DDR3 Avalon arbiter.
`timescale 1ns/1ps
package ddr3_arb_pkg;
  localparam int DEF_ADDR_W = 26;
  localparam int DEF_DATA_W = 128;
  localparam int CNT_W      = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD_CMD,
    ST_RD_DATA,
    ST_DONE
  } arb_state_e;

  typedef logic req_idx_t;

  function automatic req_idx_t onehot_to_idx(input logic [1:0] oh);
    return oh[1];
  endfunction
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: on a tie the requester that was not served last wins.
`timescale 1ns/1ps
module rr_arb2
  import ddr3_arb_pkg::*;
(
  input  logic [1:0] req,
  input  req_idx_t   last_grant,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_grant == 1'b1) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/ddr3_port_arbiter.sv
// Shares one DDR3 controller Avalon port between two single-beat requesters.
// Grant is held from command issue through the one-cycle DONE ack; reads are guarded by a timeout.
`timescale 1ns/1ps
module ddr3_port_arbiter
  import ddr3_arb_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int RD_TIMEOUT = 255
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              r0_read,
  input  logic              r1_read,
  input  logic              r0_write,
  input  logic              r1_write,
  input  logic [ADDR_W-1:0] r0_address,
  input  logic [ADDR_W-1:0] r1_address,
  input  logic [DATA_W-1:0] r0_writedata,
  input  logic [DATA_W-1:0] r1_writedata,
  output logic              r0_wait_request_n,
  output logic              r1_wait_request_n,
  output logic [DATA_W-1:0] r0_readdata,
  output logic [DATA_W-1:0] r1_readdata,
  output logic              r0_readdatavalid,
  output logic              r1_readdatavalid,
  output logic [ADDR_W-1:0] avl_address,
  output logic [DATA_W-1:0] avl_writedata,
  output logic              avl_read,
  output logic              avl_write,
  output logic              avl_burstbegin,
  input  logic              avl_wait_request_n,
  input  logic [DATA_W-1:0] avl_readdata,
  input  logic              avl_readdatavalid,
  output logic [1:0]        grant,
  output logic              timeout_err
);

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(RD_TIMEOUT);

  arb_state_e             state_q, state_d;
  req_idx_t               last_grant_q, last_grant_d;
  logic [1:0]             grant_q, grant_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;
  logic                   rd_q, rd_d;
  logic                   wr_q, wr_d;
  logic                   burst_q, burst_d;
  logic                   terr_q, terr_d;
  logic [1:0]             ack_q, ack_d;
  logic [1:0]             rvalid_q, rvalid_d;
  logic [1:0][DATA_W-1:0] rdata_q, rdata_d;

  logic [1:0] req;
  logic [1:0] pick;
  req_idx_t   pick_idx;
  req_idx_t   owner;
  logic       sel_write;

  assign req       = {r1_read | r1_write, r0_read | r0_write};
  assign pick_idx  = onehot_to_idx(pick);
  assign owner     = onehot_to_idx(grant_q);
  assign sel_write = pick_idx ? r1_write : r0_write;

  rr_arb2 u_rr_arb2 (
    .req        (req),
    .last_grant (last_grant_q),
    .gnt        (pick)
  );

  // A requester asserting read and write together is served as a write.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rd_d         = rd_q;
    wr_d         = wr_q;
    burst_d      = 1'b0;
    terr_d       = terr_q;
    ack_d        = 2'b00;
    rvalid_d     = 2'b00;
    rdata_d      = rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (|pick) begin
          grant_d = pick;
          addr_d  = pick_idx ? r1_address : r0_address;
          wdata_d = pick_idx ? r1_writedata : r0_writedata;
          burst_d = 1'b1;
          if (sel_write) begin
            wr_d    = 1'b1;
            state_d = ST_WR;
          end else begin
            rd_d    = 1'b1;
            state_d = ST_RD_CMD;
          end
        end
      end
      ST_WR: begin
        if (avl_wait_request_n) begin
          wr_d    = 1'b0;
          ack_d   = grant_q;
          state_d = ST_DONE;
        end
      end
      ST_RD_CMD: begin
        if (avl_wait_request_n) begin
          rd_d    = 1'b0;
          cnt_d   = '0;
          state_d = ST_RD_DATA;
        end
      end
      // Real data wins over a timeout landing in the same cycle.
      ST_RD_DATA: begin
        if (avl_readdatavalid) begin
          rdata_d[owner] = avl_readdata;
          ack_d          = grant_q;
          rvalid_d       = grant_q;
          cnt_d          = '0;
          state_d        = ST_DONE;
        end else if (cnt_q == TIMEOUT_CNT) begin
          rdata_d[owner] = '0;
          terr_d         = 1'b1;
          ack_d          = grant_q;
          rvalid_d       = grant_q;
          cnt_d          = '0;
          state_d        = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        last_grant_d = owner;
        grant_d      = 2'b00;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 2'b00;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      burst_q      <= 1'b0;
      terr_q       <= 1'b0;
      ack_q        <= 2'b00;
      rvalid_q     <= 2'b00;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      burst_q      <= burst_d;
      terr_q       <= terr_d;
      ack_q        <= ack_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
    end
  end

  assign avl_address       = addr_q;
  assign avl_writedata     = wdata_q;
  assign avl_read          = rd_q;
  assign avl_write         = wr_q;
  assign avl_burstbegin    = burst_q;
  assign grant             = grant_q;
  assign timeout_err       = terr_q;
  assign r0_wait_request_n = ack_q[0];
  assign r1_wait_request_n = ack_q[1];
  assign r0_readdatavalid  = rvalid_q[0];
  assign r1_readdatavalid  = rvalid_q[1];
  assign r0_readdata       = rdata_q[0];
  assign r1_readdata       = rdata_q[1];

endmodule

// File: tb/tb_ddr3_port_arbiter.sv
// Bench for ddr3_port_arbiter: directed cycle tables, targeted read/timeout/reset sequences,
// then random traffic checked against a transaction-level model of the arbitration rules.
`timescale 1ns/1ps
module tb_ddr3_port_arbiter;
  localparam int AW = 26;
  localparam int DW = 128;
  localparam int T  = 8;

  logic          iCLK;
  logic          iRST;
  logic          r0_read, r1_read, r0_write, r1_write;
  logic [AW-1:0] r0_address, r1_address;
  logic [DW-1:0] r0_writedata, r1_writedata;
  logic          r0_wait_request_n, r1_wait_request_n;
  logic [DW-1:0] r0_readdata, r1_readdata;
  logic          r0_readdatavalid, r1_readdatavalid;
  logic [AW-1:0] avl_address;
  logic [DW-1:0] avl_writedata;
  logic          avl_read, avl_write, avl_burstbegin;
  logic          avl_wait_request_n;
  logic [DW-1:0] avl_readdata;
  logic          avl_readdatavalid;
  logic [1:0]    grant;
  logic          timeout_err;

  ddr3_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_TIMEOUT(T)) dut (
    .iCLK               (iCLK),
    .iRST               (iRST),
    .r0_read            (r0_read),
    .r1_read            (r1_read),
    .r0_write           (r0_write),
    .r1_write           (r1_write),
    .r0_address         (r0_address),
    .r1_address         (r1_address),
    .r0_writedata       (r0_writedata),
    .r1_writedata       (r1_writedata),
    .r0_wait_request_n  (r0_wait_request_n),
    .r1_wait_request_n  (r1_wait_request_n),
    .r0_readdata        (r0_readdata),
    .r1_readdata        (r1_readdata),
    .r0_readdatavalid   (r0_readdatavalid),
    .r1_readdatavalid   (r1_readdatavalid),
    .avl_address        (avl_address),
    .avl_writedata      (avl_writedata),
    .avl_read           (avl_read),
    .avl_write          (avl_write),
    .avl_burstbegin     (avl_burstbegin),
    .avl_wait_request_n (avl_wait_request_n),
    .avl_readdata       (avl_readdata),
    .avl_readdatavalid  (avl_readdatavalid),
    .grant              (grant),
    .timeout_err        (timeout_err)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Transaction-level model state
  bit             pend [2];
  bit             kw [2];
  bit             kr [2];
  logic [AW-1:0]  maddr [2];
  logic [DW-1:0]  mwdata [2];
  logic [DW-1:0]  exp_rdata [2];
  logic [DW-1:0]  mem [logic [AW-1:0]];
  int             last_served;
  bit             exp_terr;

  typedef struct {
    bit            rst;
    bit            r0w, r0r, r1w, r1r, wrn;
    logic [1:0]    e_grant;
    logic          e_wr, e_rd, e_bb;
    logic [1:0]    e_ack, e_rv;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  function automatic logic [255:0] pack(logic [1:0] g, logic wr, logic rd, logic bb,
                                        logic [1:0] ack, logic [1:0] rv, logic terr,
                                        logic [AW-1:0] a, logic [DW-1:0] d);
    return {92'b0, g, wr, rd, bb, ack, rv, terr, a, d};
  endfunction

  function automatic logic [255:0] obsVec();
    return pack(grant, avl_write, avl_read, avl_burstbegin,
                {r1_wait_request_n, r0_wait_request_n},
                {r1_readdatavalid, r0_readdatavalid},
                timeout_err, avl_address, avl_writedata);
  endfunction

  function automatic vec_t mk(bit rst, bit r0w, bit r0r, bit r1w, bit r1r, bit wrn,
                              logic [1:0] g, logic wr, logic rd, logic bb,
                              logic [1:0] ack, logic [1:0] rv,
                              logic [AW-1:0] a, logic [DW-1:0] d);
    vec_t v;
    v.rst = rst; v.r0w = r0w; v.r0r = r0r; v.r1w = r1w; v.r1r = r1r; v.wrn = wrn;
    v.e_grant = g; v.e_wr = wr; v.e_rd = rd; v.e_bb = bb;
    v.e_ack = ack; v.e_rv = rv; v.e_addr = a; v.e_wdata = d;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    r0_write           = v.r0w;
    r0_read            = v.r0r;
    r1_write           = v.r1w;
    r1_read            = v.r1r;
    avl_wait_request_n = v.wrn;
  endtask

  task automatic doReset();
    r0_read = 0; r0_write = 0; r1_read = 0; r1_write = 0;
    avl_readdatavalid = 0; avl_wait_request_n = 0;
    iRST = 1;
    tick();
    tick();
    iRST = 0;
  endtask

  task automatic modelReset();
    last_served  = 1;
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
    exp_terr     = 0;
    pend[0]      = 0;
    pend[1]      = 0;
  endtask

  task automatic driveReqs();
    r0_write     = pend[0] && kw[0];
    r0_read      = pend[0] && kr[0];
    r1_write     = pend[1] && kw[1];
    r1_read      = pend[1] && kr[1];
    r0_address   = maddr[0];
    r1_address   = maddr[1];
    r0_writedata = mwdata[0];
    r1_writedata = mwdata[1];
  endtask

  function automatic logic [DW-1:0] memRead(logic [AW-1:0] a);
    if (mem.exists(a)) return mem[a];
    return {4{6'h2A, a}};
  endfunction

  task automatic newReq(input int r);
    int k;
    k         = int'($urandom_range(0, 2));
    pend[r]   = 1;
    kw[r]     = (k != 1);
    kr[r]     = (k != 0);
    maddr[r]  = AW'($urandom_range(0, 15));
    mwdata[r] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Serves one transaction starting in an IDLE cycle with requests already driven.
  // lat < 0 means the controller never answers the read.
  task automatic serveOne(input int stall, input int lat);
    int         win;
    bit         isw;
    logic [1:0] oh;
    int         jd;
    logic [DW-1:0] rdv_data;
    win = (pend[0] && pend[1]) ? 1 - last_served : (pend[0] ? 0 : 1);
    isw = kw[win];
    oh  = (win == 1) ? 2'b10 : 2'b01;

    tick();
    checkOutput("cmd_issue", obsVec(),
                pack(oh, isw, !isw, 1'b1, 2'b00, 2'b00, exp_terr, maddr[win], mwdata[win]));
    avl_wait_request_n = (stall == 0);
    avl_readdatavalid  = 1'($urandom_range(0, 1));
    avl_readdata       = {$urandom, $urandom, $urandom, $urandom};
    for (int s = 1; s <= stall; s++) begin
      tick();
      checkOutput("cmd_hold", obsVec(),
                  pack(oh, isw, !isw, 1'b0, 2'b00, 2'b00, exp_terr, maddr[win], mwdata[win]));
      avl_wait_request_n = (s == stall);
    end

    if (isw) begin
      tick();
      mem[maddr[win]] = mwdata[win];
      checkOutput("wr_done", obsVec(),
                  pack(oh, 1'b0, 1'b0, 1'b0, oh, 2'b00, exp_terr, maddr[win], mwdata[win]));
      checkOutput("wr_rdata_hold", {r1_readdata, r0_readdata}, {exp_rdata[1], exp_rdata[0]});
    end else begin
      jd = (lat >= 0) ? lat + 1 : T + 1;
      for (int j = 0; j < jd; j++) begin
        tick();
        checkOutput("rd_wait", obsVec(),
                    pack(oh, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, exp_terr, maddr[win], mwdata[win]));
        rdv_data          = memRead(maddr[win]);
        avl_readdatavalid = (j == lat);
        avl_readdata      = (j == lat) ? rdv_data : {$urandom, $urandom, $urandom, $urandom};
      end
      tick();
      if (lat >= 0) begin
        exp_rdata[win] = memRead(maddr[win]);
      end else begin
        exp_rdata[win] = '0;
        exp_terr       = 1;
      end
      checkOutput("rd_done", obsVec(),
                  pack(oh, 1'b0, 1'b0, 1'b0, oh, oh, exp_terr, maddr[win], mwdata[win]));
      checkOutput("rd_done_data", {r1_readdata, r0_readdata}, {exp_rdata[1], exp_rdata[0]});
      avl_readdatavalid = (lat < 0);
      avl_readdata      = {$urandom, $urandom, $urandom, $urandom};
    end

    pend[win] = 0;
    driveReqs();
    tick();
    avl_readdatavalid = 0;
    checkOutput("back_idle", obsVec(),
                pack(2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, exp_terr, maddr[win], mwdata[win]));
    checkOutput("idle_rdata_hold", {r1_readdata, r0_readdata}, {exp_rdata[1], exp_rdata[0]});
    last_served = win;
  endtask

  localparam logic [AW-1:0] A0 = 26'h10;
  localparam logic [AW-1:0] A1 = 26'hFF;
  localparam logic [DW-1:0] W0 = {16{8'hA5}};
  localparam logic [DW-1:0] W1 = {16{8'h5A}};

  initial begin
    int lat;
    iRST = 1;
    r0_read = 0; r0_write = 0; r1_read = 0; r1_write = 0;
    r0_address = A0; r1_address = A1; r0_writedata = W0; r1_writedata = W1;
    avl_wait_request_n = 0; avl_readdata = '0; avl_readdatavalid = 0;

    // Single write from reset, contention 01/10/01, then read+write together as a write.
    vecs.push_back(mk(1, 1,0,0,0,1, 2'b00,0,0,0, 2'b00,2'b00, '0, '0));
    vecs.push_back(mk(0, 1,0,0,0,1, 2'b01,1,0,1, 2'b00,2'b00, A0, W0));
    vecs.push_back(mk(0, 0,0,0,0,1, 2'b01,0,0,0, 2'b01,2'b00, A0, W0));
    vecs.push_back(mk(0, 0,0,0,0,1, 2'b00,0,0,0, 2'b00,2'b00, A0, W0));
    vecs.push_back(mk(1, 1,0,1,0,1, 2'b00,0,0,0, 2'b00,2'b00, '0, '0));
    vecs.push_back(mk(0, 1,0,1,0,1, 2'b01,1,0,1, 2'b00,2'b00, A0, W0));
    vecs.push_back(mk(0, 0,0,1,0,1, 2'b01,0,0,0, 2'b01,2'b00, A0, W0));
    vecs.push_back(mk(0, 1,0,1,0,1, 2'b00,0,0,0, 2'b00,2'b00, A0, W0));
    vecs.push_back(mk(0, 1,0,1,0,1, 2'b10,1,0,1, 2'b00,2'b00, A1, W1));
    vecs.push_back(mk(0, 1,0,0,0,1, 2'b10,0,0,0, 2'b10,2'b00, A1, W1));
    vecs.push_back(mk(0, 1,0,0,0,1, 2'b00,0,0,0, 2'b00,2'b00, A1, W1));
    vecs.push_back(mk(0, 0,0,0,0,1, 2'b01,1,0,1, 2'b00,2'b00, A0, W0));
    vecs.push_back(mk(0, 0,0,1,1,1, 2'b01,0,0,0, 2'b01,2'b00, A0, W0));
    vecs.push_back(mk(0, 0,0,1,1,1, 2'b00,0,0,0, 2'b00,2'b00, A0, W0));
    vecs.push_back(mk(0, 0,0,1,1,1, 2'b10,1,0,1, 2'b00,2'b00, A1, W1));
    vecs.push_back(mk(0, 0,0,0,0,1, 2'b10,0,0,0, 2'b10,2'b00, A1, W1));
    vecs.push_back(mk(0, 0,0,0,0,1, 2'b00,0,0,0, 2'b00,2'b00, A1, W1));

    foreach (vecs[i]) begin
      if (vecs[i].rst) doReset();
      else tick();
      checkOutput($sformatf("vec%0d", i), obsVec(),
                  pack(vecs[i].e_grant, vecs[i].e_wr, vecs[i].e_rd, vecs[i].e_bb,
                       vecs[i].e_ack, vecs[i].e_rv, 1'b0, vecs[i].e_addr, vecs[i].e_wdata));
      applyStimulus(vecs[i]);
    end

    // r1 read, 3 stall cycles, data four cycles after accept
    doReset();
    modelReset();
    mem[A1] = 128'h1234;
    maddr[0] = A0; mwdata[0] = W0; kw[0] = 0; kr[0] = 0;
    pend[1] = 1; kw[1] = 0; kr[1] = 1; maddr[1] = A1; mwdata[1] = W1;
    driveReqs();
    serveOne(3, 3);

    // r0 read with data, then r0 read that times out
    checkOutput("terr_before_timeout", {255'b0, timeout_err}, 256'b0);
    pend[0] = 1; kw[0] = 0; kr[0] = 1; maddr[0] = A0;
    driveReqs();
    serveOne(0, 0);
    pend[0] = 1;
    driveReqs();
    serveOne(1, -1);
    pend[1] = 1; kw[1] = 1; kr[1] = 0; maddr[1] = 26'h30; mwdata[1] = {4{32'hCAFE0001}};
    driveReqs();
    serveOne(0, 0);

    // Reset asserted while waiting for read data
    pend[1] = 1; kw[1] = 0; kr[1] = 1; maddr[1] = A1;
    driveReqs();
    avl_wait_request_n = 1;
    tick();
    checkOutput("pre_reset_cmd", obsVec(),
                pack(2'b10, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, exp_terr, A1, mwdata[1]));
    tick();
    tick();
    #2;
    iRST = 1;
    #1;
    checkOutput("reset_async_outputs", obsVec(), 256'b0);
    checkOutput("reset_async_rdata", {r1_readdata, r0_readdata}, 256'b0);
    modelReset();
    driveReqs();
    tick();
    tick();
    iRST = 0;
    avl_readdatavalid = 1;
    avl_readdata      = {4{32'hDEADBEEF}};
    tick();
    avl_readdatavalid = 0;
    checkOutput("stray_valid_ignored", obsVec(), 256'b0);
    checkOutput("stray_valid_rdata", {r1_readdata, r0_readdata}, 256'b0);
    tick();
    checkOutput("idle_after_reset", obsVec(), 256'b0);
    pend[1] = 1; kw[1] = 1; kr[1] = 0; maddr[1] = 26'h21; mwdata[1] = {4{32'h0BADF00D}};
    driveReqs();
    serveOne(1, 0);

    // Random traffic against the transaction model
    for (int n = 0; n < 150; n++) begin
      for (int r = 0; r < 2; r++)
        if (!pend[r] && $urandom_range(0, 1) == 1) newReq(r);
      if (!pend[0] && !pend[1]) newReq(int'($urandom_range(0, 1)));
      driveReqs();
      if ($urandom_range(0, 4) == 0) lat = -1;
      else lat = int'($urandom_range(0, T - 1));
      serveOne(int'($urandom_range(0, 3)), lat);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
